// File: rtl/usb_reg_fe_mc.sv
// Multi-channel USB register frontend: host async bus -> per-channel read/write strobes.
// Optional `USB_FE_RDPIPE_EN registers reg_datai ahead of the channel mux (+1 read latency).
module usb_reg_fe_mc #(
   parameter int pADDR_WIDTH   = 21,
   parameter int pBYTECNT_SIZE = 7,
   parameter int pCHSEL_WIDTH  = 2,
   parameter int pCHANNELS     = 4,
   parameter int pISOUT_HOLD   = 3
) (
   input  logic                                          usb_clk,
   input  logic                                          rst,
   input  logic [7:0]                                    usb_din,
   output logic [7:0]                                    usb_dout,
   output logic                                          usb_isout,
   input  logic [pADDR_WIDTH-1:0]                        usb_addr,
   input  logic                                          usb_rdn,
   input  logic                                          usb_wrn,
   input  logic                                          usb_cen,
   output logic [pADDR_WIDTH-pCHSEL_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
   output logic [pBYTECNT_SIZE-1:0]                      reg_bytecnt,
   output logic [pCHANNELS-1:0]                          reg_chsel,
   output logic [7:0]                                    reg_datao,
   input  logic [8*pCHANNELS-1:0]                        reg_datai,
   output logic                                          reg_read,
   output logic                                          reg_write,
   output logic                                          err_sticky
);

   localparam int RA_W   = pADDR_WIDTH - pCHSEL_WIDTH - pBYTECNT_SIZE;
   localparam int HOLD_W = $clog2(pISOUT_HOLD + 1);

   typedef enum logic [2:0] {IDLE, RD_STB, RD_CAP, RD_WAIT, WR_STB, WR_WAIT} state_t;

   state_t                   state, state_next;
   logic [pADDR_WIDTH-1:0]   addr_r;
   logic [7:0]               din_r;
   logic                     rdn_r, wrn_r, cen_r;
   logic [pCHSEL_WIDTH-1:0]  ch_idx, ch_q;
   logic                     ch_valid, ch_ok_q;
   logic [pCHANNELS-1:0]     chsel_dec;
   logic [7:0]               rd_byte;
   logic [8*pCHANNELS-1:0]   mux_src;
   logic [HOLD_W-1:0]        hold_cnt;
   logic                     armed, rst_q;
   logic                     start_rd, start_wr, set_err, load_dout;
`ifdef USB_FE_RDPIPE_EN
   logic [8*pCHANNELS-1:0]   datai_q;
   logic                     cap_wait;
`endif

   always_ff @(posedge usb_clk) begin
      if (rst) begin
         addr_r <= '0;
         din_r  <= '0;
         rdn_r  <= 1'b1;
         wrn_r  <= 1'b1;
         cen_r  <= 1'b1;
      end else begin
         addr_r <= usb_addr;
         din_r  <= usb_din;
         rdn_r  <= usb_rdn;
         wrn_r  <= usb_wrn;
         cen_r  <= usb_cen;
      end
   end

   assign ch_idx   = addr_r[pADDR_WIDTH-1 -: pCHSEL_WIDTH];
   assign ch_valid = (32'(ch_idx) < 32'(pCHANNELS));

   always_comb begin
      chsel_dec = '0;
      for (int unsigned c = 0; c < pCHANNELS; c++)
         if (32'(ch_idx) == c) chsel_dec[c] = 1'b1;
   end

`ifdef USB_FE_RDPIPE_EN
   always_ff @(posedge usb_clk) begin
      if (rst) begin
         datai_q  <= '0;
         cap_wait <= 1'b0;
      end else begin
         datai_q  <= reg_datai;
         cap_wait <= (state == RD_STB);
      end
   end
   assign mux_src = datai_q;
`else
   assign mux_src = reg_datai;
`endif

   always_comb begin
      rd_byte = '0;
      for (int unsigned c = 0; c < pCHANNELS; c++)
         if (32'(ch_q) == c) rd_byte = mux_src[8*c +: 8];
   end

   always_comb begin
      state_next = state;
      start_rd   = 1'b0;
      start_wr   = 1'b0;
      set_err    = 1'b0;
      load_dout  = 1'b0;
      case (state)
         IDLE: begin
            if (armed && !cen_r && !rdn_r) begin
               state_next = RD_STB;
               start_rd   = 1'b1;
               set_err    = !wrn_r;
            end else if (armed && !cen_r && !wrn_r) begin
               state_next = WR_STB;
               start_wr   = 1'b1;
            end
         end
         RD_STB: state_next = RD_CAP;
         RD_CAP: begin
`ifdef USB_FE_RDPIPE_EN
            if (!cap_wait) begin
               load_dout  = 1'b1;
               set_err    = !ch_ok_q;
               state_next = RD_WAIT;
            end
`else
            load_dout  = 1'b1;
            set_err    = !ch_ok_q;
            state_next = RD_WAIT;
`endif
         end
         RD_WAIT: if (rdn_r || cen_r) state_next = IDLE;
         WR_STB: begin
            set_err    = !ch_ok_q;
            state_next = WR_WAIT;
         end
         WR_WAIT: if (wrn_r || cen_r) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge usb_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Re-arm needs rdn/wrn seen high; rst_q blocks the reset-forced high values from arming.
   always_ff @(posedge usb_clk) begin
      if (rst) begin
         armed <= 1'b0;
         rst_q <= 1'b1;
      end else begin
         rst_q <= 1'b0;
         if (start_rd || start_wr)        armed <= 1'b0;
         else if (!rst_q && rdn_r && wrn_r) armed <= 1'b1;
      end
   end

   always_ff @(posedge usb_clk) begin
      if (rst) begin
         reg_address <= '0;
         reg_bytecnt <= '0;
         reg_chsel   <= '0;
         reg_datao   <= '0;
         ch_q        <= '0;
         ch_ok_q     <= 1'b0;
         usb_dout    <= '0;
         err_sticky  <= 1'b0;
      end else begin
         if (start_rd || start_wr) begin
            reg_address <= addr_r[pBYTECNT_SIZE +: RA_W];
            reg_bytecnt <= addr_r[pBYTECNT_SIZE-1:0];
            reg_chsel   <= chsel_dec;
            ch_q        <= ch_idx;
            ch_ok_q     <= ch_valid;
         end
         if (start_wr)  reg_datao  <= din_r;
         if (load_dout) usb_dout   <= rd_byte;
         if (set_err)   err_sticky <= 1'b1;
      end
   end

   assign reg_read  = (state == RD_STB);
   assign reg_write = (state == WR_STB) && ch_ok_q;

   // Loaded on the edge where rdn_r rises so usb_isout has no gap between rdn_r and the hold.
   always_ff @(posedge usb_clk) begin
      if (rst)                      hold_cnt <= '0;
      else if (usb_rdn && !rdn_r)   hold_cnt <= HOLD_W'(pISOUT_HOLD);
      else if (!usb_rdn && rdn_r)   hold_cnt <= '0;
      else if (hold_cnt != '0)      hold_cnt <= hold_cnt - 1'b1;
   end

   assign usb_isout = !rdn_r || (hold_cnt != '0);

endmodule
